// File: rtl/distribute_1xn_cmd_flow_buf_pkg.sv
// rtl/distribute_1xn_cmd_flow_buf_pkg.sv - shared helpers for distribute/reduce tree nodes
//
// Purpose: width helpers reused by the distribute and reduce nodes.
//   clog2         : ceiling log2 of a positive value (1 -> 0, 2 -> 1, 4 -> 2, ...)
//   out_cmd_width : width of the command forwarded to the next tree stage once
//                   this stage's destination mask has been stripped off. The
//                   result is never 0; a last stage forwards a single 1'b0.
package distribute_1xn_cmd_flow_buf_pkg;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int out_cmd_width(input int in_cmd_width, input int tag_width);
    return (in_cmd_width > tag_width) ? (in_cmd_width - tag_width) : 1;
  endfunction

endpackage

// File: rtl/distribute_out_fifo.sv
// rtl/distribute_out_fifo.sv - per-output synchronous FIFO for the 1xN distributor
//
// Purpose: small first-word-fall-through FIFO holding {payload, forwarded cmd}.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-low reset; clears pointers and count
//   push  in   write din this edge (ignored when full)
//   pop   in   drop the head entry this edge (ignored when empty)
//   din   in   WIDTH-bit entry to write
//   dout  out  current head entry (contents undefined when empty)
//   count out  number of stored entries, 0..DEPTH
//   empty out  count == 0
module distribute_out_fifo
  import distribute_1xn_cmd_flow_buf_pkg::*;
#(
  parameter int WIDTH = 34,
  parameter int DEPTH = 2,
  localparam int AW   = clog2(DEPTH),
  localparam int CW   = clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage needs no reset: the count gates whether an entry is ever seen.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/distribute_1xn_cmd_flow_buf.sv
// rtl/distribute_1xn_cmd_flow_buf.sv - buffered 1xN command-flow distributor
//
// Purpose: fans one valid/ready input stream out to NUM_DATA_OUT outputs. The
// top DESTINATION_TAG_WIDTH bits of i_cmd select the outputs (unicast or
// multicast); the remaining low bits travel with the flit to the next stage.
// Each output has its own FIFO so a stalled output never loses data.
// Ports:
//   clk, rst    clock and asynchronous active-low reset
//   i_en        acceptance enable (outputs keep draining when low)
//   i_valid     input flit valid
//   o_ready     input accepted this cycle when i_valid is also high
//   i_data_bus  input payload
//   i_cmd       {this stage's mask, next-stage command}
//   o_valid     per-output valid
//   i_ready     per-output downstream ready
//   o_data_bus  output k at [k*DATA_WIDTH +: DATA_WIDTH], zero when empty
//   o_cmd       output k at [k*OUT_COMMAND_WIDTH +: OUT_COMMAND_WIDTH], zero when empty
//   o_drop      one-cycle pulse after a zero-mask flit was accepted and discarded
module distribute_1xn_cmd_flow_buf
  import distribute_1xn_cmd_flow_buf_pkg::*;
#(
  parameter int DATA_WIDTH            = 32,
  parameter int NUM_DATA_OUT          = 4,
  parameter int DESTINATION_TAG_WIDTH = NUM_DATA_OUT,
  parameter int IN_COMMAND_WIDTH      = 6,
  parameter int FIFO_DEPTH            = 2,
  localparam int OUT_COMMAND_WIDTH    = out_cmd_width(IN_COMMAND_WIDTH, DESTINATION_TAG_WIDTH)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_en,
  input  logic                                  i_valid,
  output logic                                  o_ready,
  input  logic [DATA_WIDTH-1:0]                 i_data_bus,
  input  logic [IN_COMMAND_WIDTH-1:0]           i_cmd,
  output logic [NUM_DATA_OUT-1:0]               o_valid,
  input  logic [NUM_DATA_OUT-1:0]               i_ready,
  output logic [NUM_DATA_OUT*DATA_WIDTH-1:0]    o_data_bus,
  output logic [NUM_DATA_OUT*OUT_COMMAND_WIDTH-1:0] o_cmd,
  output logic                                  o_drop
);

  localparam int FW = DATA_WIDTH + OUT_COMMAND_WIDTH;
  localparam int CW = clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [DESTINATION_TAG_WIDTH-1:0] mask;
  logic [OUT_COMMAND_WIDTH-1:0]     next_cmd;
  logic [FW-1:0]                    fifo_din;
  logic [FW-1:0]                    fifo_dout [NUM_DATA_OUT];
  logic [CW-1:0]                    fifo_cnt  [NUM_DATA_OUT];
  logic [NUM_DATA_OUT-1:0]          fifo_empty;
  logic [NUM_DATA_OUT-1:0]          lane_room;
  logic [NUM_DATA_OUT-1:0]          push;
  logic [NUM_DATA_OUT-1:0]          pop;
  logic                             accept;

  assign mask = i_cmd[IN_COMMAND_WIDTH-1 -: DESTINATION_TAG_WIDTH];

  if (IN_COMMAND_WIDTH > DESTINATION_TAG_WIDTH) begin : g_fwd_cmd
    assign next_cmd = i_cmd[IN_COMMAND_WIDTH-DESTINATION_TAG_WIDTH-1:0];
  end else begin : g_last_stage
    assign next_cmd = '0;
  end

  assign fifo_din = {i_data_bus, next_cmd};

  // Ready looks only at registered counts, never at i_ready, so a pop in the
  // same cycle does not open a slot until the next cycle. Multicast is
  // all-or-nothing: every selected lane must have room.
  assign o_ready = rst & i_en & (&(~mask | lane_room));
  assign accept  = i_valid & o_ready;
  assign push    = {NUM_DATA_OUT{accept}} & mask;
  assign pop     = o_valid & i_ready;

  for (genvar k = 0; k < NUM_DATA_OUT; k++) begin : g_lane
    distribute_out_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[k]),
      .pop   (pop[k]),
      .din   (fifo_din),
      .dout  (fifo_dout[k]),
      .count (fifo_cnt[k]),
      .empty (fifo_empty[k])
    );

    assign lane_room[k] = (fifo_cnt[k] < DEPTH_C);
    assign o_valid[k]   = ~fifo_empty[k];
    assign o_data_bus[k*DATA_WIDTH +: DATA_WIDTH] =
      fifo_empty[k] ? '0 : fifo_dout[k][FW-1 -: DATA_WIDTH];
    assign o_cmd[k*OUT_COMMAND_WIDTH +: OUT_COMMAND_WIDTH] =
      fifo_empty[k] ? '0 : fifo_dout[k][OUT_COMMAND_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_drop <= 1'b0;
    end else begin
      o_drop <= accept & (mask == '0);
    end
  end

endmodule

// File: tb/tb_distribute_1xn_cmd_flow_buf.sv
// tb/tb_distribute_1xn_cmd_flow_buf.sv - directed self-checking bench for the 1xN distributor
module tb_distribute_1xn_cmd_flow_buf;

  logic         clk;
  logic         rst;
  logic         i_en;
  logic         i_valid;
  logic         o_ready;
  logic [31:0]  i_data_bus;
  logic [5:0]   i_cmd;
  logic [3:0]   o_valid;
  logic [3:0]   i_ready;
  logic [127:0] o_data_bus;
  logic [7:0]   o_cmd;
  logic         o_drop;

  int total;
  int bad;

  distribute_1xn_cmd_flow_buf #(
    .DATA_WIDTH            (32),
    .NUM_DATA_OUT          (4),
    .DESTINATION_TAG_WIDTH (4),
    .IN_COMMAND_WIDTH      (6),
    .FIFO_DEPTH            (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_en       (i_en),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data_bus (i_data_bus),
    .i_cmd      (i_cmd),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data_bus (o_data_bus),
    .o_cmd      (o_cmd),
    .o_drop     (o_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; i_en = 1'b1; i_valid = 1'b1; i_cmd = 6'b111100;
    i_data_bus = 32'h12345678; i_ready = 4'h0;
    tick(); tick();
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", o_ready); end
    total++; if (o_valid !== 4'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0000", o_valid); end
    total++; if (o_data_bus !== 128'h0 || o_cmd !== 8'h0 || o_drop !== 1'b0) begin
      bad++; $display("FAIL reset_outputs data=%h cmd=%h drop=%b exp zero", o_data_bus, o_cmd, o_drop); end
    i_valid = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_unicast();
    i_ready = 4'hF; i_cmd = 6'b0100_10; i_data_bus = 32'hAAAAAAAA; i_valid = 1'b1;
    #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL uni_ready got=%b exp=1", o_ready); end
    @(posedge clk); #1;
    i_valid = 1'b0;
    total++; if (o_valid !== 4'b0100) begin bad++; $display("FAIL uni_valid got=%b exp=0100", o_valid); end
    total++; if (o_data_bus !== {32'h0, 32'hAAAAAAAA, 64'h0}) begin
      bad++; $display("FAIL uni_data got=%h exp=lane2 AAAAAAAA", o_data_bus); end
    total++; if (o_cmd !== 8'b00_10_00_00) begin bad++; $display("FAIL uni_cmd got=%b exp=00100000", o_cmd); end
    tick();
    total++; if (o_valid !== 4'b0000) begin bad++; $display("FAIL uni_popped got=%b exp=0000", o_valid); end
  endtask

  task automatic test_multicast_backpressure();
    i_ready = 4'h0; i_cmd = 6'b1011_01; i_valid = 1'b1;
    i_data_bus = 32'hA0A0A0A0; #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL mc_ready_a got=%b exp=1", o_ready); end
    @(posedge clk); #1;
    i_data_bus = 32'hB0B0B0B0; #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL mc_ready_b got=%b exp=1", o_ready); end
    @(posedge clk); #1;
    i_data_bus = 32'hC0C0C0C0; #1;
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL mc_ready_c_full got=%b exp=0", o_ready); end
    total++; if (o_valid !== 4'b1011 || o_data_bus !== {32'hA0A0A0A0, 32'h0, 32'hA0A0A0A0, 32'hA0A0A0A0}
                 || o_cmd !== 8'b01_00_01_01) begin
      bad++; $display("FAIL mc_head_a valid=%b data=%h cmd=%b", o_valid, o_data_bus, o_cmd); end
    i_ready = 4'hF; #1;
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL mc_conservative got=%b exp=0", o_ready); end
    @(posedge clk); #1;
    total++; if (o_data_bus !== {32'hB0B0B0B0, 32'h0, 32'hB0B0B0B0, 32'hB0B0B0B0}) begin
      bad++; $display("FAIL mc_head_b got=%h", o_data_bus); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL mc_ready_after_pop got=%b exp=1", o_ready); end
    @(posedge clk); #1;
    i_valid = 1'b0;
    total++; if (o_valid !== 4'b1011 || o_data_bus !== {32'hC0C0C0C0, 32'h0, 32'hC0C0C0C0, 32'hC0C0C0C0}) begin
      bad++; $display("FAIL mc_head_c valid=%b data=%h", o_valid, o_data_bus); end
    tick();
    total++; if (o_valid !== 4'b0000) begin bad++; $display("FAIL mc_drained got=%b exp=0000", o_valid); end
  endtask

  task automatic test_independent_drain();
    i_ready = 4'h0; i_cmd = 6'b1000_00; i_valid = 1'b1;
    i_data_bus = 32'h33330001; tick();
    i_data_bus = 32'h33330002; tick();
    i_ready = 4'b0001; i_cmd = 6'b0001_11; i_data_bus = 32'hD0D0D0D0; #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL ind_ready got=%b exp=1", o_ready); end
    @(posedge clk); #1;
    i_valid = 1'b0;
    total++; if (o_valid !== 4'b1001 || o_data_bus !== {32'h33330001, 64'h0, 32'hD0D0D0D0}
                 || o_cmd !== 8'b00_00_00_11) begin
      bad++; $display("FAIL ind_lane0 valid=%b data=%h cmd=%b", o_valid, o_data_bus, o_cmd); end
    tick();
    total++; if (o_valid !== 4'b1000 || o_data_bus[127:96] !== 32'h33330001) begin
      bad++; $display("FAIL ind_lane3_held valid=%b data3=%h", o_valid, o_data_bus[127:96]); end
    i_ready = 4'hF;
    tick();
    total++; if (o_data_bus[127:96] !== 32'h33330002) begin
      bad++; $display("FAIL ind_lane3_second got=%h exp=33330002", o_data_bus[127:96]); end
    tick();
    total++; if (o_valid !== 4'b0000) begin bad++; $display("FAIL ind_drained got=%b exp=0000", o_valid); end
  endtask

  task automatic test_zero_mask();
    i_ready = 4'hF; i_cmd = 6'b0000_11; i_data_bus = 32'hDEADBEEF; i_valid = 1'b1; #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL zm_ready got=%b exp=1", o_ready); end
    @(posedge clk); #1;
    i_valid = 1'b0;
    total++; if (o_drop !== 1'b1 || o_valid !== 4'b0000) begin
      bad++; $display("FAIL zm_drop drop=%b valid=%b exp 1/0000", o_drop, o_valid); end
    tick();
    total++; if (o_drop !== 1'b0) begin bad++; $display("FAIL zm_drop_one_cycle got=%b exp=0", o_drop); end
  endtask

  task automatic test_enable();
    i_ready = 4'h0; i_cmd = 6'b0010_00; i_data_bus = 32'h11112222; i_valid = 1'b1;
    tick();
    i_en = 1'b0; i_cmd = 6'b0100_00; #1;
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL en_ready got=%b exp=0", o_ready); end
    i_ready = 4'hF;
    tick();
    total++; if (o_valid !== 4'b0000) begin bad++; $display("FAIL en_drain got=%b exp=0000", o_valid); end
    i_en = 1'b1; i_valid = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    i_ready = 4'h0; i_cmd = 6'b1111_00; i_valid = 1'b1;
    i_data_bus = 32'h55550001; tick();
    i_data_bus = 32'h55550002; tick();
    i_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    total++; if (o_valid !== 4'b0000 || o_ready !== 1'b0) begin
      bad++; $display("FAIL rst_async valid=%b ready=%b exp 0000/0", o_valid, o_ready); end
    #1 rst = 1'b1;
    tick();
    i_valid = 1'b1; i_data_bus = 32'h66660001; #1;
    total++; if (o_ready !== 1'b1 || o_valid !== 4'b0000) begin
      bad++; $display("FAIL rst_cleared ready=%b valid=%b exp 1/0000", o_ready, o_valid); end
    @(posedge clk); #1;
    i_data_bus = 32'h66660002; #1;
    total++; if (o_ready !== 1'b1 || o_data_bus !== {4{32'h66660001}}) begin
      bad++; $display("FAIL rst_refill ready=%b data=%h", o_ready, o_data_bus); end
    @(posedge clk); #1;
    i_valid = 1'b0; i_ready = 4'hF;
    tick(); tick();
    total++; if (o_valid !== 4'b0000) begin bad++; $display("FAIL rst_final_drain got=%b exp=0000", o_valid); end
  endtask

  task automatic test_wrap_around();
    int sent;
    int recv;
    logic [31:0] exp_data;
    logic [1:0]  exp_cmd;
    sent = 0; recv = 0;
    i_ready = 4'b0010;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (o_valid[1]) begin
        exp_data = 32'h10000000 + recv;
        exp_cmd  = 2'(recv % 4);
        total++; if (o_data_bus[63:32] !== exp_data || o_cmd[3:2] !== exp_cmd) begin
          bad++; $display("FAIL wrap_flit%0d data=%h cmd=%b exp=%h/%b", recv, o_data_bus[63:32], o_cmd[3:2], exp_data, exp_cmd); end
        recv++;
      end
      if ((o_valid & 4'b1101) !== 4'b0000) begin
        total++; bad++; $display("FAIL wrap_other_lane valid=%b", o_valid);
      end
      if (sent < 10) begin
        i_valid = 1'b1; i_data_bus = 32'h10000000 + sent; i_cmd = {4'b0010, 2'(sent % 4)};
      end else begin
        i_valid = 1'b0;
      end
      #1;
      if (i_valid && o_ready) sent++;
      else if (i_valid) begin
        total++; bad++; $display("FAIL wrap_stall at flit %0d ready=%b exp=1", sent, o_ready);
      end
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    total++; if (recv !== 10 || sent !== 10) begin
      bad++; $display("FAIL wrap_count recv=%0d sent=%0d exp=10", recv, sent); end
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_unicast();
    test_multicast_backpressure();
    test_independent_drain();
    test_zero_mask();
    test_enable();
    test_reset_mid_burst();
    test_wrap_around();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
